// File: rtl/uart_matrix_rx.sv
// UART byte receiver (8N1) that packs every four received bytes into a 2x2 matrix word
// and offers it to a consumer with a valid/ready handshake.
module uart_matrix_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 86800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic [1:0]  elem_cnt,
    output logic        busy
);

    // Handshake: a matrix transfers on every cycle where m_valid && m_ready are both high;
    // m_data is frozen while m_valid is high, and reception never waits on m_ready.

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_C  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] BIT_C   = CW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic          rx_s;
    logic [1:0]    settle_q, settle_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          err_wait_q, err_wait_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [1:0]    elem_cnt_q, elem_cnt_d;
    logic [23:0]   part_q, part_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          start_det;
    logic          stop_bad;

    assign rx_s = sync2_q;

    // Two-flop synchronizer, preset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q     <= 2'd0;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            err_wait_q   <= 1'b0;
            byte_data_q  <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            elem_cnt_q   <= 2'd0;
            part_q       <= 24'd0;
            m_data_q     <= 32'd0;
            m_valid_q    <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            settle_q     <= settle_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            err_wait_q   <= err_wait_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            elem_cnt_q   <= elem_cnt_d;
            part_q       <= part_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    // Start is accepted only once the synchronized line has been seen high after reset,
    // so a line that is still low when reset releases does not open a bogus frame.
    assign start_det = (state_q == S_IDLE) && armed_q && !rx_s;

    always_comb begin
        state_d      = state_q;
        settle_d     = (settle_q == 2'd2) ? 2'd2 : settle_q + 2'd1;
        armed_d      = armed_q | ((settle_q == 2'd2) && rx_s);
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        err_wait_d   = err_wait_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        elem_cnt_d   = elem_cnt_q;
        part_d       = part_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        to_cnt_d     = to_cnt_q;
        stop_bad     = 1'b0;

        // cnt_q holds the number of cycles elapsed since T0 or since the last sample.
        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    state_d = S_START;
                    cnt_d   = CW'(1);
                end
            end
            S_START: begin
                if (cnt_q == HALF_C) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = CW'(1);
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_C) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = CW'(1);
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (err_wait_q) begin
                    if (rx_s) begin
                        state_d    = S_IDLE;
                        err_wait_d = 1'b0;
                    end
                end else if (cnt_q == BIT_C) begin
                    if (rx_s) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        err_wait_d  = 1'b1;
                        stop_bad    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        // Matrix assembly runs in the byte_valid cycle, so a load lands one cycle later.
        if (byte_valid_q) begin
            to_cnt_d   = '0;
            elem_cnt_d = elem_cnt_q + 2'd1;
            case (elem_cnt_q)
                2'd0: part_d[7:0]   = byte_data_q;
                2'd1: part_d[15:8]  = byte_data_q;
                2'd2: part_d[23:16] = byte_data_q;
                default: begin
                    if (!m_valid_q || m_ready) begin
                        m_data_d  = {byte_data_q, part_q};
                        m_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            endcase
        end else if (stop_bad) begin
            elem_cnt_d = 2'd0;
            to_cnt_d   = '0;
        end else if (start_det) begin
            to_cnt_d = '0;
        end else if ((state_q == S_IDLE) && (elem_cnt_q != 2'd0)) begin
            if (to_cnt_q == TO_LAST) begin
                elem_cnt_d = 2'd0;
                to_cnt_d   = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        byte_data  = byte_data_q;
        byte_valid = byte_valid_q;
        m_data     = m_data_q;
        m_valid    = m_valid_q;
        frame_err  = frame_err_q;
        overrun    = overrun_q;
        elem_cnt   = elem_cnt_q;
    end

endmodule

// File: doc/uart_matrix_rx.md
UART_MATRIX_RX -- requirements
Module: uart_matrix_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 86800, meaning idle clocks after a byte before a partial matrix is discarded.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port uart_rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port byte_data  output  8  last received byte.
REQ-007 SHALL have port byte_valid  output  1  one-cycle pulse; byte_data is valid in that cycle.
REQ-008 SHALL have port m_data  output  32  assembled 2x2 matrix; element0 in [7:0], element3 in [31:24].
REQ-009 SHALL have port m_valid  output  1  m_data holds an unconsumed matrix.
REQ-010 SHALL have port m_ready  input  1  consumer accepts m_data when m_valid && m_ready.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a completed matrix is dropped.
REQ-013 SHALL have port elem_cnt  output  2  number of bytes held in the partial matrix, 0..3.
REQ-014 SHALL have port busy  output  1  high while the bit FSM is not IDLE.

Function
REQ-015 SHALL pass uart_rx through a 2-flop synchronizer, and all FSM decisions SHALL use the synchronized value (2-cycle input latency).
REQ-016 SHALL implement the bit FSM with states IDLE, START, DATA and STOP.
REQ-017 SHALL move IDLE->START on the first cycle the synchronized line is 0; that cycle is T0.
REQ-018 SHALL sample the line at T0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT: k=0 is the start bit, k=1..8 are data bits LSB first, k=9 is the stop bit.
REQ-019 SHALL treat a start-bit sample of 1 as a glitch: return to IDLE with no pulses and no state change elsewhere.
REQ-020 SHALL, when the stop sample is 1, pulse byte_valid in the next cycle with byte_data = received byte, then return to IDLE.
REQ-021 SHALL, when the stop sample is 0, pulse frame_err in the next cycle with no byte_valid, clear elem_cnt to 0, and return to IDLE only after the line has been sampled high.
REQ-022 SHALL hold byte_data between pulses.
REQ-023 SHALL store each valid byte at element index elem_cnt and then increment elem_cnt.
REQ-024 SHALL, on the 4th byte:
  - if m_valid==0, or m_ready==1 in the same cycle: load m_data and set m_valid the cycle after byte_valid;
  - otherwise: keep m_data, pulse overrun, and discard the new matrix.
  - In both cases elem_cnt wraps to 0.
REQ-025 SHALL clear m_valid on the cycle after m_valid && m_ready when no new matrix loads in that same cycle; m_data SHALL be held stable while m_valid==1.
REQ-026 SHALL count idle clocks in IDLE while elem_cnt!=0, reset the count on each start detection, and on reaching TIMEOUT_CLKS clear elem_cnt to 0 (no pulse).
REQ-027 SHALL never allow busy, byte reception, and an m_ready handshake to block one another; byte reception is never stalled by the consumer.

Reset
REQ-028 SHALL, with rst high on a clock edge, set the FSM to IDLE, elem_cnt=0, byte_data=0, m_data=0, and deassert byte_valid, m_valid, frame_err, overrun and busy.
REQ-029 SHALL preset the synchronizer flops to 1 on reset.
REQ-030 SHALL discard a byte in progress when reset occurs mid-frame; the next falling edge after reset starts a fresh frame.

Verification
REQ-031 Matrix: bytes 01,02,03,04 at 8680 ns/bit with m_ready=1 -> four byte_valid pulses, m_data=32'h04030201, m_valid high for 1 cycle.
REQ-032 Glitch: uart_rx low for 100 clks, then high -> no byte_valid, no frame_err, busy returns low, elem_cnt unchanged.
REQ-033 Framing: 0x55 sent with stop=0 after 2 good bytes -> frame_err pulse, elem_cnt=0; next 4 bytes AA,BB,CC,DD -> m_data=32'hDDCCBBAA.
REQ-034 Overrun: m_ready=0, two matrices 01..04 then 05..08 -> m_data stays 32'h04030201 with m_valid=1, one overrun pulse; m_ready=1 clears m_valid.
REQ-035 Timeout: 2 bytes, then line idle for TIMEOUT_CLKS+10 -> elem_cnt=0; following 4 bytes form a complete matrix.
REQ-036 Reset mid-byte: rst asserted during data bit 4 -> all outputs at reset values; next full byte 0x3C -> byte_valid with byte_data=8'h3C, elem_cnt=1.
